// File: rtl/spi_slave_fifo.sv
// rtl/spi_slave_fifo.sv - SPI slave: 2-bit command frames in, FIFO-buffered read responses out
module spi_slave_fifo #(
  parameter int DATA_W    = 8,
  parameter int TX_DEPTH  = 4,
  parameter int LSB_FIRST = 0
) (
  input  logic                          i_spi_slave_fifo_clk,
  input  logic                          i_spi_slave_fifo_rst,
  input  logic                          i_spi_slave_fifo_ss_bar,
  input  logic                          i_spi_slave_fifo_mosi,
  input  logic [DATA_W-1:0]             i_spi_slave_fifo_tx_data,
  input  logic                          i_spi_slave_fifo_tx_valid,
  output logic                          o_spi_slave_fifo_tx_ready,
  output logic [$clog2(TX_DEPTH+1)-1:0] o_spi_slave_fifo_tx_level,
  output logic [DATA_W+1:0]             o_spi_slave_fifo_rx_data,
  output logic                          o_spi_slave_fifo_rx_valid,
  output logic                          o_spi_slave_fifo_miso,
  output logic                          o_spi_slave_fifo_miso_valid,
  output logic                          o_spi_slave_fifo_sready,
  output logic                          o_spi_slave_fifo_underrun,
  output logic                          o_spi_slave_fifo_frame_err
);

  localparam int CW = $clog2(DATA_W+3);
  localparam int AW = $clog2(TX_DEPTH);
  localparam int LW = $clog2(TX_DEPTH+1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RX   = 2'd1;
  localparam logic [1:0] S_TX   = 2'd2;
  localparam logic [1:0] S_WAIT = 2'd3;

  localparam logic [CW-1:0] CMD_LAST = CW'(1);
  localparam logic [CW-1:0] RX_LAST  = CW'(DATA_W+1);
  localparam logic [CW-1:0] TX_LAST  = CW'(DATA_W-1);
  localparam logic [LW-1:0] FULL_LVL = LW'(TX_DEPTH);

  logic [1:0]        state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [1:0]        cmd_q, cmd_d;
  logic [DATA_W-1:0] pay_q, pay_d, pay_shift;
  logic [DATA_W+1:0] rx_data_q, rx_data_d;
  logic              rx_valid_q, rx_valid_d;
  logic              frame_err_q, frame_err_d;
  logic              underrun_q, underrun_d;
  logic [DATA_W-1:0] tx_sh_q, tx_sh_d, tx_next;
  logic              miso_q, miso_d;
  logic              miso_valid_q, miso_valid_d;
  logic              starve_q, starve_d;
  logic              active_q;

  logic [DATA_W-1:0] mem [TX_DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]     level_q;
  logic              empty, full, push, pop_req, do_pop;
  logic [DATA_W-1:0] head;

  function automatic logic lead_bit(input logic [DATA_W-1:0] w);
    return (LSB_FIRST != 0) ? w[0] : w[DATA_W-1];
  endfunction

  assign empty  = (level_q == '0);
  assign full   = (level_q == FULL_LVL);
  assign head   = mem[rd_ptr_q];
  // active_q holds tx_ready/sready low for the first cycle out of reset
  assign push   = i_spi_slave_fifo_tx_valid && active_q && !full;
  assign do_pop = pop_req && !empty;

  assign pay_shift = (LSB_FIRST != 0) ? {i_spi_slave_fifo_mosi, pay_q[DATA_W-1:1]}
                                      : {pay_q[DATA_W-2:0], i_spi_slave_fifo_mosi};
  assign tx_next   = (LSB_FIRST != 0) ? (tx_sh_q >> 1) : (tx_sh_q << 1);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    cmd_d        = cmd_q;
    pay_d        = pay_q;
    rx_data_d    = rx_data_q;
    rx_valid_d   = 1'b0;
    frame_err_d  = 1'b0;
    underrun_d   = 1'b0;
    tx_sh_d      = tx_sh_q;
    miso_d       = miso_q;
    miso_valid_d = miso_valid_q;
    starve_d     = starve_q;
    pop_req      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!i_spi_slave_fifo_ss_bar) begin
          state_d = S_RX;
          cnt_d   = '0;
        end
      end
      S_RX: begin
        if (i_spi_slave_fifo_ss_bar) begin
          state_d     = S_IDLE;
          frame_err_d = 1'b1;
        end else begin
          if (cnt_q <= CMD_LAST) cmd_d = {cmd_q[0], i_spi_slave_fifo_mosi};
          else                   pay_d = pay_shift;
          if (cnt_q == RX_LAST) begin
            rx_data_d  = {cmd_q, pay_shift};
            rx_valid_d = 1'b1;
            cnt_d      = '0;
            if (cmd_q == 2'b11) begin
              // an empty pop still runs the TX slot, silently, so frame timing is preserved
              state_d      = S_TX;
              pop_req      = 1'b1;
              starve_d     = empty;
              underrun_d   = empty;
              tx_sh_d      = head;
              miso_d       = !empty && lead_bit(head);
              miso_valid_d = !empty;
            end else begin
              state_d = S_WAIT;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_TX: begin
        if (i_spi_slave_fifo_ss_bar) begin
          state_d      = S_IDLE;
          frame_err_d  = 1'b1;
          miso_d       = 1'b0;
          miso_valid_d = 1'b0;
        end else if (cnt_q == TX_LAST) begin
          state_d      = S_WAIT;
          miso_d       = 1'b0;
          miso_valid_d = 1'b0;
        end else begin
          cnt_d   = cnt_q + 1'b1;
          tx_sh_d = tx_next;
          miso_d  = !starve_q && lead_bit(tx_next);
        end
      end
      default: begin
        miso_d       = 1'b0;
        miso_valid_d = 1'b0;
        if (i_spi_slave_fifo_ss_bar) state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_spi_slave_fifo_clk) begin
    if (i_spi_slave_fifo_rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      cmd_q        <= '0;
      pay_q        <= '0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      frame_err_q  <= 1'b0;
      underrun_q   <= 1'b0;
      tx_sh_q      <= '0;
      miso_q       <= 1'b0;
      miso_valid_q <= 1'b0;
      starve_q     <= 1'b0;
      active_q     <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      cmd_q        <= cmd_d;
      pay_q        <= pay_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      frame_err_q  <= frame_err_d;
      underrun_q   <= underrun_d;
      tx_sh_q      <= tx_sh_d;
      miso_q       <= miso_d;
      miso_valid_q <= miso_valid_d;
      starve_q     <= starve_d;
      active_q     <= 1'b1;
      wr_ptr_q     <= wr_ptr_q + AW'(push);
      rd_ptr_q     <= rd_ptr_q + AW'(do_pop);
      level_q      <= level_q + LW'(push) - LW'(do_pop);
    end
  end

  always_ff @(posedge i_spi_slave_fifo_clk) begin
    if (push) mem[wr_ptr_q] <= i_spi_slave_fifo_tx_data;
  end

  assign o_spi_slave_fifo_tx_ready   = active_q && !full;
  assign o_spi_slave_fifo_tx_level   = level_q;
  assign o_spi_slave_fifo_rx_data    = rx_data_q;
  assign o_spi_slave_fifo_rx_valid   = rx_valid_q;
  assign o_spi_slave_fifo_miso       = miso_q;
  assign o_spi_slave_fifo_miso_valid = miso_valid_q;
  assign o_spi_slave_fifo_sready     = active_q && (state_q == S_IDLE);
  assign o_spi_slave_fifo_underrun   = underrun_q;
  assign o_spi_slave_fifo_frame_err  = frame_err_q;

endmodule

// File: tb/tb_spi_slave_fifo.sv
// tb/tb_spi_slave_fifo.sv - directed and randomized checks of spi_slave_fifo against a queue model
module tb_spi_slave_fifo;
  localparam int DW    = 8;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, ss_bar, mosi, tx_valid;
  logic [DW-1:0] tx_data;

  logic tx_ready, rx_valid, miso, miso_valid, sready, underrun, frame_err;
  logic [2:0] tx_level;
  logic [DW+1:0] rx_data;
  logic tx_ready_l, rx_valid_l, miso_l, miso_valid_l, sready_l, underrun_l, frame_err_l;
  logic [2:0] tx_level_l;
  logic [DW+1:0] rx_data_l;

  int n_chk = 0;
  int n_fail = 0;
  logic [DW-1:0] q[$];

  spi_slave_fifo #(.DATA_W(DW), .TX_DEPTH(DEPTH), .LSB_FIRST(0)) dut (
    .i_spi_slave_fifo_clk(clk), .i_spi_slave_fifo_rst(rst),
    .i_spi_slave_fifo_ss_bar(ss_bar), .i_spi_slave_fifo_mosi(mosi),
    .i_spi_slave_fifo_tx_data(tx_data), .i_spi_slave_fifo_tx_valid(tx_valid),
    .o_spi_slave_fifo_tx_ready(tx_ready), .o_spi_slave_fifo_tx_level(tx_level),
    .o_spi_slave_fifo_rx_data(rx_data), .o_spi_slave_fifo_rx_valid(rx_valid),
    .o_spi_slave_fifo_miso(miso), .o_spi_slave_fifo_miso_valid(miso_valid),
    .o_spi_slave_fifo_sready(sready), .o_spi_slave_fifo_underrun(underrun),
    .o_spi_slave_fifo_frame_err(frame_err));

  spi_slave_fifo #(.DATA_W(DW), .TX_DEPTH(DEPTH), .LSB_FIRST(1)) dut_lsb (
    .i_spi_slave_fifo_clk(clk), .i_spi_slave_fifo_rst(rst),
    .i_spi_slave_fifo_ss_bar(ss_bar), .i_spi_slave_fifo_mosi(mosi),
    .i_spi_slave_fifo_tx_data(tx_data), .i_spi_slave_fifo_tx_valid(tx_valid),
    .o_spi_slave_fifo_tx_ready(tx_ready_l), .o_spi_slave_fifo_tx_level(tx_level_l),
    .o_spi_slave_fifo_rx_data(rx_data_l), .o_spi_slave_fifo_rx_valid(rx_valid_l),
    .o_spi_slave_fifo_miso(miso_l), .o_spi_slave_fifo_miso_valid(miso_valid_l),
    .o_spi_slave_fifo_sready(sready_l), .o_spi_slave_fifo_underrun(underrun_l),
    .o_spi_slave_fifo_frame_err(frame_err_l));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] rev(input logic [DW-1:0] w);
    logic [DW-1:0] r;
    for (int i = 0; i < DW; i++) r[i] = w[DW-1-i];
    return r;
  endfunction

  task automatic push(input logic [DW-1:0] w);
    chk("tx_ready", tx_ready, q.size() < DEPTH);
    tx_valid = 1'b1;
    tx_data  = w;
    tick();
    tx_valid = 1'b0;
    if (q.size() < DEPTH) q.push_back(w);
    chk("tx_level", tx_level, q.size());
  endtask

  // abort_at: bit index at which ss_bar rises instead (>= DW+2 means no abort)
  task automatic frame(input logic [1:0] cmd, input logic [DW-1:0] pay, input int abort_at,
                       input bit push_pop, input logic [DW-1:0] pw);
    logic [DW+1:0] fr;
    logic [DW-1:0] word;
    bit starve;
    int lvl;
    fr = {cmd, pay};
    ss_bar = 1'b0;
    tick();
    chk("sready_in_rx", sready, 0);
    for (int i = 0; i < DW+2; i++) begin
      if (i == abort_at) begin
        ss_bar = 1'b1;
        tick();
        chk("frame_err", frame_err, 1);
        chk("rx_valid_abort", rx_valid, 0);
        chk("sready_after_abort", sready, 1);
        chk("tx_level_abort", tx_level, q.size());
        tick();
        chk("frame_err_pulse", frame_err, 0);
        return;
      end
      mosi = fr[DW+1-i];
      if (i == DW+1 && push_pop) begin
        tx_valid = 1'b1;
        tx_data  = pw;
      end
      tick();
      if (i < DW+1) chk("rx_valid_early", rx_valid, 0);
    end
    tx_valid = 1'b0;
    lvl    = q.size();
    starve = (cmd == 2'b11) && (lvl == 0);
    word   = '0;
    if (cmd == 2'b11 && !starve) word = q.pop_front();
    if (push_pop && lvl < DEPTH) q.push_back(pw);
    chk("rx_valid", rx_valid, 1);
    chk("rx_data", rx_data, fr);
    chk("rx_data_lsb", rx_data_l, {cmd, rev(pay)});
    chk("frame_err_ok", frame_err, 0);
    chk("underrun", underrun, starve);
    chk("tx_level_pop", tx_level, q.size());
    if (cmd == 2'b11) begin
      for (int b = 0; b < DW; b++) begin
        if (b > 0) begin
          tick();
          chk("rx_valid_pulse", rx_valid, 0);
          chk("underrun_pulse", underrun, 0);
        end
        chk("miso_valid", miso_valid, !starve);
        chk("miso", miso, starve ? 1'b0 : word[DW-1-b]);
        chk("miso_lsb", miso_l, starve ? 1'b0 : word[b]);
      end
    end
    tick();
    chk("miso_valid_end", miso_valid, 0);
    chk("miso_end", miso, 0);
    chk("rx_valid_end", rx_valid, 0);
    chk("sready_wait", sready, 0);
    ss_bar = 1'b1;
    tick();
    chk("sready_idle", sready, 1);
    chk("frame_err_clean", frame_err, 0);
  endtask

  initial begin
    logic [DW+1:0] fr;
    rst = 1'b1; ss_bar = 1'b1; mosi = 1'b0; tx_valid = 1'b0; tx_data = '0;

    // reset state
    repeat (3) tick();
    chk("rst_tx_ready", tx_ready, 0);
    chk("rst_tx_level", tx_level, 0);
    chk("rst_rx_data", rx_data, 0);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_miso", miso, 0);
    chk("rst_miso_valid", miso_valid, 0);
    chk("rst_sready", sready, 0);
    chk("rst_underrun", underrun, 0);
    chk("rst_frame_err", frame_err, 0);
    rst = 1'b0;
    tick();
    chk("post_rst_sready", sready, 1);
    chk("post_rst_tx_ready", tx_ready, 1);
    chk("post_rst_level", tx_level, 0);

    // write frame 10'b0110101101
    frame(2'b01, 8'hAD, 99, 1'b0, '0);
    chk("write_rx_data_const", rx_data, 10'h1AD);

    // reads of AA then CC
    push(8'hAA);
    push(8'hCC);
    frame(2'b11, 8'h00, 99, 1'b0, '0);
    frame(2'b11, 8'h00, 99, 1'b0, '0);

    // underrun on empty FIFO, with a push landing on the pop edge
    frame(2'b11, 8'h00, 99, 1'b0, '0);
    frame(2'b11, 8'h3C, 99, 1'b1, 8'h77);
    frame(2'b11, 8'h00, 99, 1'b0, '0);

    // full FIFO: 5th push ignored, then pop with push at full and at level 3
    for (int i = 0; i < 5; i++) push(DW'($urandom));
    chk("full_tx_ready", tx_ready, 0);
    chk("full_level", tx_level, 4);
    frame(2'b11, 8'h00, 99, 1'b1, 8'h11);
    frame(2'b11, 8'h00, 99, 1'b1, 8'h22);

    // abort after 5 bits
    frame(2'b10, 8'h5A, 5, 1'b0, '0);

    // reset during TX
    push(8'h5A);
    ss_bar = 1'b0;
    tick();
    fr = {2'b11, 8'h00};
    for (int i = 0; i < DW+2; i++) begin
      mosi = fr[DW+1-i];
      tick();
    end
    tick();
    tick();
    chk("tx_active", miso_valid, 1);
    rst = 1'b1;
    tick();
    chk("rst_tx_miso", miso, 0);
    chk("rst_tx_miso_valid", miso_valid, 0);
    chk("rst_tx_level", tx_level, 0);
    chk("rst_tx_rx_valid", rx_valid, 0);
    q.delete();
    rst = 1'b0;
    ss_bar = 1'b1;
    tick();
    chk("rst_tx_sready", sready, 1);
    chk("rst_tx_ready", tx_ready, 1);

    // randomized traffic
    repeat (40) begin
      if ($urandom_range(0, 2) == 0) begin
        push(DW'($urandom));
      end else begin
        frame(2'($urandom), DW'($urandom),
              ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, DW+1)) : 99,
              1'($urandom_range(0, 1)), DW'($urandom));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
